// File: rtl/player_state_dynamic.sv
// Frame-stepped player character: walking, edge-armed jumping, gravity, landing and clamping.
// Optional build macro PLAYER_AIR_CONTROL_EN enables horizontal control while airborne.
module player_state_dynamic #(
  parameter int unsigned SCREEN_WIDTH   = 640,
  parameter int unsigned SCREEN_HEIGHT  = 480,
  parameter int unsigned CHAR_WIDTH     = 32,
  parameter int unsigned CHAR_HEIGHT    = 60,
  parameter int unsigned FLOOR_OFFSET   = 40,
  parameter int unsigned WALK_SPEED     = 4,
  parameter int unsigned JUMP_VEL       = 12,
  parameter int unsigned GRAVITY        = 1,
  parameter int unsigned MAX_FALL       = 12,
  parameter logic [7:0]  CHAR_COLOR_332 = 8'b11111110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] char_x_pos_out,
  output logic [9:0] char_y_pos_out,
  output logic [9:0] char_width_out,
  output logic [9:0] char_height_out,
  output logic [7:0] char_color_out_332,
  output logic       on_ground,
  output logic       facing_left
);

  localparam int unsigned FloorY = SCREEN_HEIGHT - CHAR_HEIGHT - FLOOR_OFFSET;
  localparam int unsigned XMax   = SCREEN_WIDTH - CHAR_WIDTH;
  localparam int unsigned XStart = SCREEN_WIDTH / 2 - CHAR_WIDTH / 2;

  localparam logic signed [11:0] FloorY12  = 12'(FloorY);
  localparam logic signed [11:0] XMax12    = 12'(XMax);
  localparam logic signed [11:0] Walk12    = 12'(WALK_SPEED);
  localparam logic signed [11:0] Grav12    = 12'(GRAVITY);
  localparam logic signed [11:0] MaxFall12 = 12'(MAX_FALL);
  localparam logic signed [7:0]  JumpVel8  = 8'(JUMP_VEL);

  typedef enum logic [1:0] {StGrounded, StRising, StFalling} state_e;

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [7:0] vy_q, vy_d;
  logic              facing_q, facing_d;
  logic              armed_q, armed_d;
  logic              ground_q;

  logic signed [11:0] x_sum, y_sum, vy_sum;
  logic               walk_en;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    armed_d  = armed_q;
    x_sum    = 12'sd0;
    y_sum    = 12'sd0;
    vy_sum   = 12'sd0;
`ifdef PLAYER_AIR_CONTROL_EN
    walk_en  = 1'b1;
`else
    walk_en  = (state_q == StGrounded);
`endif

    if (frame_tick) begin
      armed_d = ~btn_jump;

      if (walk_en && btn_left && !btn_right) begin
        x_sum    = $signed({2'b00, x_q}) - Walk12;
        x_d      = (x_sum < 12'sd0) ? 10'd0 : x_sum[9:0];
        facing_d = 1'b1;
      end else if (walk_en && btn_right && !btn_left) begin
        x_sum    = $signed({2'b00, x_q}) + Walk12;
        x_d      = (x_sum > XMax12) ? XMax12[9:0] : x_sum[9:0];
        facing_d = 1'b0;
      end

      if (state_q == StGrounded) begin
        if (btn_jump && armed_q) begin
          vy_d    = -JumpVel8;
          state_d = StRising;
        end
      end else begin
        y_sum  = $signed({2'b00, y_q}) + {{4{vy_q[7]}}, vy_q};
        vy_sum = {{4{vy_q[7]}}, vy_q} + Grav12;
        // Landing wins over the ceiling and over normal flight.
        if (y_sum >= FloorY12) begin
          y_d     = FloorY12[9:0];
          vy_d    = 8'sd0;
          state_d = StGrounded;
        end else if (y_sum < 12'sd0) begin
          y_d     = 10'd0;
          vy_d    = 8'sd0;
          state_d = StFalling;
        end else begin
          y_d     = y_sum[9:0];
          vy_d    = (vy_sum > MaxFall12) ? MaxFall12[7:0] : vy_sum[7:0];
          state_d = (vy_sum >= 12'sd0) ? StFalling : StRising;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StGrounded;
      x_q      <= 10'(XStart);
      y_q      <= 10'(FloorY);
      vy_q     <= 8'sd0;
      facing_q <= 1'b0;
      armed_q  <= 1'b0;
      ground_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      armed_q  <= armed_d;
      ground_q <= (state_d == StGrounded);
    end
  end

  assign char_x_pos_out     = x_q;
  assign char_y_pos_out     = y_q;
  assign on_ground          = ground_q;
  assign facing_left        = facing_q;
  assign char_width_out     = 10'(CHAR_WIDTH);
  assign char_height_out    = 10'(CHAR_HEIGHT);
  assign char_color_out_332 = CHAR_COLOR_332;

endmodule

// File: tb/tb_player_state_dynamic.sv
// Directed and randomized bench for player_state_dynamic against a kinematic reference model.
`timescale 1ns/100ps
module tb_player_state_dynamic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] char_x_pos_out, char_y_pos_out, char_width_out, char_height_out;
  logic [7:0] char_color_out_332;
  logic       on_ground, facing_left;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer kinematics, grounded/airborne only.
  int mx, my, mvy;
  bit m_ground, m_facing, m_armed;

  player_state_dynamic dut (
    .clk                (clk),
    .rst                (rst),
    .frame_tick         (frame_tick),
    .btn_left           (btn_left),
    .btn_right          (btn_right),
    .btn_jump           (btn_jump),
    .char_x_pos_out     (char_x_pos_out),
    .char_y_pos_out     (char_y_pos_out),
    .char_width_out     (char_width_out),
    .char_height_out    (char_height_out),
    .char_color_out_332 (char_color_out_332),
    .on_ground          (on_ground),
    .facing_left        (facing_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 304; my = 380; mvy = 0;
    m_ground = 1'b1; m_facing = 1'b0; m_armed = 1'b0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    bit can_walk;
    int ny, nvy;
    can_walk = m_ground;
`ifdef PLAYER_AIR_CONTROL_EN
    can_walk = 1'b1;
`endif
    if (can_walk && l && !r) begin
      mx = (mx - 4 < 0) ? 0 : mx - 4;
      m_facing = 1'b1;
    end else if (can_walk && r && !l) begin
      mx = (mx + 4 > 608) ? 608 : mx + 4;
      m_facing = 1'b0;
    end
    if (m_ground) begin
      if (j && m_armed) begin
        mvy = -12;
        m_ground = 1'b0;
      end
    end else begin
      ny  = my + mvy;
      nvy = (mvy + 1 > 12) ? 12 : mvy + 1;
      if (ny >= 380) begin
        my = 380; mvy = 0; m_ground = 1'b1;
      end else if (ny < 0) begin
        my = 0; mvy = 0;
      end else begin
        my = ny; mvy = nvy;
      end
    end
    m_armed = !j;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"}, 32'(char_x_pos_out), 32'(mx));
    chk({tag, ".y"}, 32'(char_y_pos_out), 32'(my));
    chk({tag, ".on_ground"}, 32'(on_ground), 32'(m_ground));
    chk({tag, ".facing"}, 32'(facing_left), 32'(m_facing));
  endtask

  task automatic tick(input bit l, input bit r, input bit j, input string tag);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(l, r, j);
    check_all(tag);
  endtask

  // Buttons wiggle between ticks; state must not move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_left = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      btn_jump = 1'($urandom_range(0, 1));
    end
    check_all("idle");
  endtask

  initial begin
    model_reset();
    #23 rst = 1'b0;
    check_all("reset");
    chk("width", 32'(char_width_out), 32'd60 - 32'd28);
    chk("height", 32'(char_height_out), 32'd60);
    chk("color", 32'(char_color_out_332), 32'hFE);

    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, "quiet");
    chk("quiet_x", 32'(char_x_pos_out), 32'd304);
    idle(7);

    for (int i = 0; i < 80; i++) tick(1'b0, 1'b1, 1'b0, "right");
    chk("right_sat", 32'(char_x_pos_out), 32'd608);
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b0, "left");
    chk("left_sat", 32'(char_x_pos_out), 32'd0);
    chk("left_face", 32'(facing_left), 32'd1);

    // Jump held through the landing must not retrigger.
    tick(1'b0, 1'b0, 1'b0, "arm");
    tick(1'b0, 1'b0, 1'b1, "jump");
    chk("jump_y", 32'(char_y_pos_out), 32'd380);
    chk("jump_air", 32'(on_ground), 32'd0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1, "rise");
    chk("apex_y", 32'(char_y_pos_out), 32'd302);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1, "fall");
    chk("fall24_air", 32'(on_ground), 32'd0);
    tick(1'b0, 1'b0, 1'b1, "land");
    chk("land_y", 32'(char_y_pos_out), 32'd380);
    chk("land_gnd", 32'(on_ground), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, "held");
    chk("held_gnd", 32'(on_ground), 32'd1);
    tick(1'b0, 1'b0, 1'b0, "rearm");
    tick(1'b0, 1'b0, 1'b1, "rejump");
    chk("rejump_air", 32'(on_ground), 32'd0);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, "reland");

    // Mid-air horizontal control.
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, "walk");
    tick(1'b0, 1'b0, 1'b0, "arm2");
    tick(1'b0, 1'b0, 1'b1, "jump2");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, "air_both");
    chk("air_both_x", 32'(char_x_pos_out), 32'd80);
    tick(1'b1, 1'b0, 1'b0, "air_left");
`ifdef PLAYER_AIR_CONTROL_EN
    chk("air_left_x", 32'(char_x_pos_out), 32'd76);
`else
    chk("air_left_x", 32'(char_x_pos_out), 32'd80);
`endif
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, "land2");

    // Asynchronous reset mid-jump.
    tick(1'b0, 1'b0, 1'b0, "arm3");
    tick(1'b0, 1'b0, 1'b1, "jump3");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, "rise3");
    chk("pre_rst_y", 32'(char_y_pos_out), 32'd330);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    tick(1'b0, 1'b0, 1'b1, "post_rst");
    chk("post_rst_gnd", 32'(on_ground), 32'd1);

    for (int i = 0; i < 400; i++) begin
      idle(int'($urandom_range(0, 3)));
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
